program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Program loader: assembles a byte stream big-endian into instruction words and
// writes them to instruction memory from address 0, holding the CPU while it does.
module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   wr_cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  error_q;

    logic accept, last_byte, start_ok, start_go, last_word;

    assign accept    = (state == RECV) && byte_valid;
    assign last_byte = accept && (idx_q == IDX_W'(BYTES - 1));
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign start_go  = start_ok && (word_count != '0) && (word_count <= MAX_WORDS);
    // The written-word counter is one bit wider than the address so a full-depth
    // load terminates on the count instead of wrapping back to address 0.
    assign last_word = (wr_cnt_q + ONE) == count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_nxt = start_go ? RECV : DONE;
                end
            end
            RECV: begin
                if (last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = last_word ? DONE : RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_cnt_q <= '0;
            idx_q    <= '0;
            error_q  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            if (start_go) begin
                count_q  <= word_count;
                wr_cnt_q <= '0;
                idx_q    <= '0;
                error_q  <= 1'b0;
            end else if (start_ok) begin
                error_q <= (word_count > MAX_WORDS);
            end
            if (accept) begin
                idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
            end
            // Output registers only load on the edge into WRITE, so they stay stable elsewhere.
            if (last_byte) begin
                mem_addr <= wr_cnt_q[ADDR_WIDTH-1:0];
                mem_data <= {shift_q[DATA_WIDTH-9:0], byte_in};
            end
            if (state == WRITE) begin
                wr_cnt_q <= wr_cnt_q + ONE;
            end
        end
    end

    // Partial-word shifter; stale bytes are shifted out by a fresh word after reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q <= {shift_q[DATA_WIDTH-9:0], byte_in};
        end
    end

    assign byte_ready = (state == RECV);
    assign mem_we     = (state == WRITE);
    assign busy       = (state == RECV) || (state == WRITE);
    assign cpu_hold   = busy;
    assign done       = (state == DONE);
    assign error      = error_q;

endmodule
